// File: rtl/rx_stream_mux.sv
// rx_stream_mux: drains NUM_CH sample FIFOs (fixed or round-robin channel choice) and
// serialises each WORD_W-bit IQ word into OUT_W-bit valid/ready beats, MSB beat first.
module rx_stream_mux #(
  parameter int NUM_CH = 2,
  parameter int WORD_W = 32,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_rr_mode,
  input  logic [CHW-1:0]           i_ch_sel,
  input  logic                     i_cnt_clr,
  input  logic [NUM_CH-1:0]        i_fifo_empty,
  output logic [NUM_CH-1:0]        o_fifo_pull,
  input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
  output logic [OUT_W-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last,
  output logic [CHW-1:0]           o_ch_id,
  output logic [CNT_W-1:0]         o_underrun_cnt
);
  localparam int BEATS = WORD_W / OUT_W;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [1:0] IDLE = 2'd0, PULL = 2'd1, WAIT = 2'd2, SEND = 2'd3;
  logic [1:0] state;
  logic [CHW-1:0] cur_ch, ptr, rr_ch, cand;
  logic [WORD_W-1:0] sreg;
  logic [BW-1:0] beat_cnt;
  logic rr_found, sel_ok, cand_ok, starved, last_beat;
  // Scan from the farthest channel inward so the one nearest ptr+1 wins.
  always_comb begin
    rr_found = 1'b0;
    rr_ch = '0;
    for (int k = NUM_CH; k >= 1; k--)
      if (!i_fifo_empty[(int'(ptr) + k) % NUM_CH]) begin
        rr_found = 1'b1;
        rr_ch = CHW'((int'(ptr) + k) % NUM_CH);
      end
  end
  assign sel_ok = int'(i_ch_sel) < NUM_CH;
  assign cand = i_rr_mode ? rr_ch : i_ch_sel;
  assign cand_ok = i_rr_mode ? rr_found : (sel_ok && !i_fifo_empty[i_ch_sel]);
  assign starved = (state == IDLE) && i_enable && (i_rr_mode || sel_ok) && !cand_ok;
  assign last_beat = beat_cnt == BW'(BEATS - 1);
  assign o_valid = state == SEND;
  assign o_last = o_valid && last_beat;
  assign o_data = sreg[WORD_W-1 -: OUT_W];
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cur_ch <= '0;
      ptr <= CHW'(NUM_CH - 1);
      o_fifo_pull <= '0;
      sreg <= '0;
      beat_cnt <= '0;
      o_ch_id <= '0;
      o_underrun_cnt <= '0;
    end else begin
      o_underrun_cnt <= i_cnt_clr ? '0 : (starved && !(&o_underrun_cnt)) ? o_underrun_cnt + 1'b1 : o_underrun_cnt;
      case (state)
        IDLE: if (i_enable && cand_ok) begin
          cur_ch <= cand;
          o_fifo_pull <= NUM_CH'(1) << cand;
          state <= PULL;
        end
        PULL: begin
          o_fifo_pull <= '0;
          ptr <= cur_ch;
          state <= WAIT;
        end
        WAIT: begin
          sreg <= i_fifo_data[cur_ch*WORD_W +: WORD_W];
          o_ch_id <= cur_ch;
          beat_cnt <= '0;
          state <= SEND;
        end
        default: if (i_ready) begin
          sreg <= sreg << OUT_W;
          beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) state <= IDLE;
        end
      endcase
    end
  end
endmodule
